// File: rtl/i2c_cmd_arbiter.sv
// Per-channel command FIFOs feeding one I2C controller through a round-robin grant. When no
// command is queued, a default temperature poll is issued. Define POLL_THROTTLE_EN to rate-limit polls.
module i2c_cmd_arbiter #(
    parameter int              NCH       = 2,
    parameter int              DEPTH     = 4,
    parameter int              DW        = 16,
    parameter int              AW        = 8,
    parameter int              MW        = 3,
    parameter logic [AW-1:0]   POLL_ADDR = 8'h00,
    parameter logic [MW-1:0]   POLL_MODE = 3'b001,
    parameter int              POLL_IVL  = 1000,
    localparam int             GW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i2c_ready,
    input  logic [NCH-1:0]     ch_wr,
    input  logic [NCH*AW-1:0]  ch_addr,
    input  logic [NCH*DW-1:0]  ch_data,
    input  logic [NCH*MW-1:0]  ch_mode,
    output logic [NCH-1:0]     ch_full,
    output logic [NCH-1:0]     ch_drop,
    output logic [AW-1:0]      i2c_address,
    output logic [DW-1:0]      i2c_data,
    output logic [MW-1:0]      i2c_mode,
    output logic [1:0]         valid_instr,
    output logic [GW-1:0]      grant_ch
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CW   = AW + DW + MW;

    localparam logic [0:0] ARMED    = 1'b0;
    localparam logic [0:0] WAIT_LOW = 1'b1;

    localparam logic [1:0] VI_NONE = 2'b00;
    localparam logic [1:0] VI_CMD  = 2'b01;
    localparam logic [1:0] VI_POLL = 2'b11;

    if (NCH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || POLL_IVL < 1) begin : g_param_check
        $error("i2c_cmd_arbiter: illegal parameter combination");
    end

    // FIFO storage, packed as {addr, data, mode}
    logic [CW-1:0]   mem_q     [NCH][DEPTH];
    logic [PW-1:0]   wr_ptr_q  [NCH];
    logic [PW-1:0]   wr_ptr_d  [NCH];
    logic [PW-1:0]   rd_ptr_q  [NCH];
    logic [PW-1:0]   rd_ptr_d  [NCH];
    logic [CNTW-1:0] count_q   [NCH];
    logic [CNTW-1:0] count_d   [NCH];
    logic [NCH-1:0]  full_q, full_d;
    logic [NCH-1:0]  drop_q, drop_d;

    logic [0:0]      state_q, state_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [1:0]      valid_q, valid_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [MW-1:0]   mode_q, mode_d;
    logic [GW-1:0]   grant_q, grant_d;

    logic [NCH-1:0]  push, pop, nonempty;
    logic            found;
    logic [GW-1:0]   gsel, cand;
    logic [CW-1:0]   head;
    logic            poll_ok;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            nonempty[c] = (count_q[c] != '0);
        end
    end

    // Search starts one past the last granted channel so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        cand  = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand = GW'((int'(rr_q) + i) % NCH);
            if (!found && nonempty[cand]) begin
                found = 1'b1;
                gsel  = cand;
            end
        end
    end

    assign head = mem_q[gsel][rd_ptr_q[gsel]];

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        valid_d = VI_NONE;
        addr_d  = '0;
        data_d  = '0;
        mode_d  = '0;
        grant_d = '0;
        pop     = '0;
        case (state_q)
            ARMED: begin
                if (i2c_ready) begin
                    if (found) begin
                        pop[gsel]                = 1'b1;
                        rr_d                     = gsel;
                        valid_d                  = VI_CMD;
                        {addr_d, data_d, mode_d} = head;
                        grant_d                  = gsel;
                        state_d                  = WAIT_LOW;
                    end else if (poll_ok) begin
                        valid_d = VI_POLL;
                        addr_d  = POLL_ADDR;
                        mode_d  = POLL_MODE;
                        state_d = WAIT_LOW;
                    end
                end
            end
            default: begin
                if (!i2c_ready) begin
                    state_d = ARMED;
                end
            end
        endcase
    end

    // Full is the registered flag, so a write on full is dropped even if the same FIFO pops.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            push[c]     = ch_wr[c] & ~full_q[c];
            drop_d[c]   = ch_wr[c] & full_q[c];
            wr_ptr_d[c] = wr_ptr_q[c] + PW'(push[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + PW'(pop[c]);
            count_d[c]  = count_q[c] + CNTW'(push[c]) - CNTW'(pop[c]);
            full_d[c]   = (count_d[c] == CNTW'(DEPTH));
        end
    end

`ifdef POLL_THROTTLE_EN
    localparam int TW = $clog2(POLL_IVL) + 1;

    logic [TW-1:0] thr_q, thr_d;

    always_comb begin
        thr_d = thr_q;
        if (valid_d == VI_POLL) begin
            thr_d = TW'(POLL_IVL - 1);
        end else if (thr_q != '0) begin
            thr_d = thr_q - 1'b1;
        end
    end

    assign poll_ok = (thr_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            thr_q <= '0;
        end else begin
            thr_q <= thr_d;
        end
    end
`else
    assign poll_ok = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARMED;
            rr_q    <= GW'(NCH - 1);
            valid_q <= VI_NONE;
            addr_q  <= '0;
            data_q  <= '0;
            mode_q  <= '0;
            grant_q <= '0;
            full_q  <= '0;
            drop_q  <= '0;
            for (int c = 0; c < NCH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            grant_q <= grant_d;
            full_q  <= full_d;
            drop_q  <= drop_d;
            for (int c = 0; c < NCH; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                count_q[c]  <= count_d[c];
            end
        end
    end

    // NOTE: the storage array has no reset; the cleared counts make stale entries unreachable.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (push[c]) begin
                mem_q[c][wr_ptr_q[c]] <= {ch_addr[c*AW +: AW], ch_data[c*DW +: DW], ch_mode[c*MW +: MW]};
            end
        end
    end

    assign ch_full     = full_q;
    assign ch_drop     = drop_q;
    assign i2c_address = addr_q;
    assign i2c_data    = data_q;
    assign i2c_mode    = mode_q;
    assign valid_instr = valid_q;
    assign grant_ch    = grant_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter (NCH=2, DEPTH=4, POLL_IVL=8); follows POLL_THROTTLE_EN if defined.
module tb_i2c_cmd_arbiter;

`ifdef POLL_THROTTLE_EN
    localparam int PER = 8;
`else
    localparam int PER = 4;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        i2c_ready;
    logic [1:0]  ch_wr;
    logic [15:0] ch_addr;
    logic [31:0] ch_data;
    logic [5:0]  ch_mode;
    logic [1:0]  ch_full;
    logic [1:0]  ch_drop;
    logic [7:0]  i2c_address;
    logic [15:0] i2c_data;
    logic [2:0]  i2c_mode;
    logic [1:0]  valid_instr;
    logic [0:0]  grant_ch;

    int errors = 0;
    int checks = 0;

    localparam logic [29:0] OBS_POLL = {2'b11, 1'b0, 8'h00, 16'h0000, 3'b001};

    i2c_cmd_arbiter #(.NCH(2), .DEPTH(4), .POLL_IVL(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .i2c_ready  (i2c_ready),
        .ch_wr      (ch_wr),
        .ch_addr    (ch_addr),
        .ch_data    (ch_data),
        .ch_mode    (ch_mode),
        .ch_full    (ch_full),
        .ch_drop    (ch_drop),
        .i2c_address(i2c_address),
        .i2c_data   (i2c_data),
        .i2c_mode   (i2c_mode),
        .valid_instr(valid_instr),
        .grant_ch   (grant_ch)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [29:0] obs_now();
        return {valid_instr, grant_ch, i2c_address, i2c_data, i2c_mode};
    endfunction

    function automatic logic [29:0] exp_cmd(input logic g, input logic [7:0] a,
                                            input logic [15:0] d, input logic [2:0] m);
        return {2'b01, g, a, d, m};
    endfunction

    task automatic set_ch(input int ch, input logic [7:0] a, input logic [15:0] d, input logic [2:0] m);
        ch_addr[ch*8 +: 8]  = a;
        ch_data[ch*16 +: 16] = d;
        ch_mode[ch*3 +: 3]  = m;
    endtask

    task automatic wr1(input int ch, input logic [7:0] a, input logic [15:0] d, input logic [2:0] m);
        set_ch(ch, a, d, m);
        ch_wr     = '0;
        ch_wr[ch] = 1'b1;
        tick();
        ch_wr = '0;
    endtask

    task automatic pulse(output logic [29:0] o);
        i2c_ready = 1'b1;
        tick();
        o = obs_now();
        i2c_ready = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        i2c_ready = 1'b0;
        ch_wr     = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        ch_addr = '0;
        ch_data = '0;
        ch_mode = '0;
        do_reset();
        checks++;
        if (obs_now() !== 30'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs_now(), 30'h0);
        end
        checks++;
        if ({ch_full, ch_drop} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {ch_full, ch_drop});
        end
    endtask

    task automatic test_default_poll();
        logic [29:0] o;
        i2c_ready = 1'b1;
        tick();
        checks++;
        if (obs_now() !== OBS_POLL) begin
            errors++;
            $display("FAIL first_poll: got %h expected %h", obs_now(), OBS_POLL);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs_now() !== 30'h0) begin
                errors++;
                $display("FAIL no_reissue_%0d: got %h expected %h", i, obs_now(), 30'h0);
            end
        end
        i2c_ready = 1'b0;
        idle(8);
        pulse(o);
        checks++;
        if (o !== OBS_POLL) begin
            errors++;
            $display("FAIL second_poll: got %h expected %h", o, OBS_POLL);
        end
    endtask

    task automatic test_two_channels();
        logic [29:0] o;
        set_ch(0, 8'hA1, 16'h1234, 3'b010);
        set_ch(1, 8'hB2, 16'h5678, 3'b011);
        ch_wr = 2'b11;
        tick();
        ch_wr = 2'b00;
        pulse(o);
        checks++;
        if (o !== exp_cmd(1'b0, 8'hA1, 16'h1234, 3'b010)) begin
            errors++;
            $display("FAIL two_ch_first: got %h expected %h", o, exp_cmd(1'b0, 8'hA1, 16'h1234, 3'b010));
        end
        pulse(o);
        checks++;
        if (o !== exp_cmd(1'b1, 8'hB2, 16'h5678, 3'b011)) begin
            errors++;
            $display("FAIL two_ch_second: got %h expected %h", o, exp_cmd(1'b1, 8'hB2, 16'h5678, 3'b011));
        end
        idle(8);
        pulse(o);
        checks++;
        if (o !== OBS_POLL) begin
            errors++;
            $display("FAIL two_ch_poll_after: got %h expected %h", o, OBS_POLL);
        end
    endtask

    task automatic test_round_robin();
        logic [29:0] o, e;
        for (int i = 0; i < 3; i++) begin
            set_ch(0, 8'h10 + 8'(i), 16'h0100 + 16'(i), 3'b001);
            set_ch(1, 8'h20 + 8'(i), 16'h0200 + 16'(i), 3'b010);
            ch_wr = 2'b11;
            tick();
        end
        ch_wr = 2'b00;
        for (int i = 0; i < 6; i++) begin
            pulse(o);
            if (i % 2 == 0) e = exp_cmd(1'b0, 8'h10 + 8'(i / 2), 16'h0100 + 16'(i / 2), 3'b001);
            else            e = exp_cmd(1'b1, 8'h20 + 8'(i / 2), 16'h0200 + 16'(i / 2), 3'b010);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rr_issue_%0d: got %h expected %h", i, o, e);
            end
        end
        idle(8);
        pulse(o);
        checks++;
        if (o !== OBS_POLL) begin
            errors++;
            $display("FAIL rr_poll_after: got %h expected %h", o, OBS_POLL);
        end
    endtask

    task automatic test_full_drop();
        logic [29:0] o, e;
        for (int i = 0; i < 5; i++) begin
            wr1(1, 8'h30 + 8'(i), 16'h3000 + 16'(i), 3'(i));
            if (i == 2) begin
                checks++;
                if (ch_full !== 2'b00) begin
                    errors++;
                    $display("FAIL full_after_3: got %b expected 00", ch_full);
                end
            end
            if (i == 3) begin
                checks++;
                if ({ch_full, ch_drop} !== 4'b1000) begin
                    errors++;
                    $display("FAIL full_after_4: got %b expected 1000", {ch_full, ch_drop});
                end
            end
            if (i == 4) begin
                checks++;
                if ({ch_full, ch_drop} !== 4'b1010) begin
                    errors++;
                    $display("FAIL drop_on_5th: got %b expected 1010", {ch_full, ch_drop});
                end
            end
        end
        tick();
        checks++;
        if (ch_drop !== 2'b00) begin
            errors++;
            $display("FAIL drop_one_cycle: got %b expected 00", ch_drop);
        end
        for (int i = 0; i < 4; i++) begin
            pulse(o);
            e = exp_cmd(1'b1, 8'h30 + 8'(i), 16'h3000 + 16'(i), 3'(i));
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL full_drain_%0d: got %h expected %h", i, o, e);
            end
        end
        checks++;
        if (ch_full !== 2'b00) begin
            errors++;
            $display("FAIL full_cleared: got %b expected 00", ch_full);
        end
        idle(8);
        pulse(o);
        checks++;
        if (o !== OBS_POLL) begin
            errors++;
            $display("FAIL full_poll_after: got %h expected %h", o, OBS_POLL);
        end
    endtask

    task automatic test_full_pop();
        logic [29:0] o, e;
        for (int i = 0; i < 4; i++) wr1(0, 8'h50 + 8'(i), 16'h5000 + 16'(i), 3'b100);
        checks++;
        if (ch_full !== 2'b01) begin
            errors++;
            $display("FAIL pop_prefill_full: got %b expected 01", ch_full);
        end
        set_ch(0, 8'h5F, 16'h5FFF, 3'b111);
        ch_wr     = 2'b01;
        i2c_ready = 1'b1;
        tick();
        o = obs_now();
        checks++;
        if ({o, ch_drop, ch_full} !== {exp_cmd(1'b0, 8'h50, 16'h5000, 3'b100), 2'b01, 2'b00}) begin
            errors++;
            $display("FAIL pop_with_full_write: got %h/%b/%b expected %h/01/00",
                     o, ch_drop, ch_full, exp_cmd(1'b0, 8'h50, 16'h5000, 3'b100));
        end
        ch_wr     = 2'b00;
        i2c_ready = 1'b0;
        tick();
        wr1(0, 8'h54, 16'h5004, 3'b100);
        checks++;
        if ({ch_full, ch_drop} !== 4'b0100) begin
            errors++;
            $display("FAIL pop_refill: got %b expected 0100", {ch_full, ch_drop});
        end
        for (int i = 1; i < 5; i++) begin
            pulse(o);
            e = exp_cmd(1'b0, 8'h50 + 8'(i), 16'h5000 + 16'(i), 3'b100);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL pop_drain_%0d: got %h expected %h", i, o, e);
            end
        end
        idle(8);
        pulse(o);
        checks++;
        if (o !== OBS_POLL) begin
            errors++;
            $display("FAIL pop_poll_after: got %h expected %h", o, OBS_POLL);
        end
    endtask

    task automatic test_reset_midway();
        for (int i = 0; i < 4; i++) wr1(1, 8'h60 + 8'(i), 16'h6000 + 16'(i), 3'b110);
        i2c_ready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({obs_now(), ch_full, ch_drop} !== 34'h0) begin
            errors++;
            $display("FAIL midway_reset_state: got %h/%b/%b expected all zero", obs_now(), ch_full, ch_drop);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (obs_now() !== OBS_POLL) begin
            errors++;
            $display("FAIL midway_fifos_discarded: got %h expected %h", obs_now(), OBS_POLL);
        end
        i2c_ready = 1'b0;
        tick();
    endtask

    // Ready high for 2 cycles, low for 2; one command lands while ready is low.
    task automatic test_poll_cadence();
        logic [29:0] e;
        do_reset();
        set_ch(0, 8'h77, 16'h7777, 3'b101);
        for (int k = 1; k <= 44; k++) begin
            i2c_ready = (((k - 1) / 2) % 2 == 0);
            ch_wr     = (k == 35) ? 2'b01 : 2'b00;
            tick();
            if (k == 37)          e = exp_cmd(1'b0, 8'h77, 16'h7777, 3'b101);
            else if (k % PER == 1) e = OBS_POLL;
            else                   e = 30'h0;
            checks++;
            if (obs_now() !== e) begin
                errors++;
                $display("FAIL cadence_edge_%0d: got %h expected %h", k, obs_now(), e);
            end
        end
        ch_wr     = 2'b00;
        i2c_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_default_poll();
        test_two_channels();
        test_round_robin();
        test_full_drop();
        test_full_pop();
        test_reset_midway();
        test_poll_cadence();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
